// File: rtl/anillo_pkg.sv
// Shared widths, FSM state encoding and lane helper for the systolic ring sequencer.
package anillo_pkg;
  localparam int W      = 16;
  localparam int N_PE   = 4;
  localparam int ADDR_W = 8;
  localparam int IDX_W  = $clog2(N_PE);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, DRAIN, COLLECT, OUT} state_t;

  typedef logic [N_PE*W-1:0] lanes_t;

  function automatic logic [W-1:0] lane(input lanes_t v, input int unsigned i);
    return v[i*W +: W];
  endfunction
endpackage

// File: rtl/anillo_if.sv
// Host, matrix RAM, ring and result-stream signals of the ring sequencer.
interface anillo_if;
  import anillo_pkg::*;

  logic              start_valid;
  logic              start_ready;
  lanes_t            x_in;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  lanes_t            mem_rdata;
  logic              ring_rst;
  lanes_t            ring_x_init;
  lanes_t            ring_a;
  logic [W-1:0]      ring_y;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic              res_last;
  logic              busy;
  logic              done;

  modport slave (
    input  start_valid, x_in, base_addr, mem_rdata, ring_y, res_ready,
    output start_ready, mem_rd_en, mem_addr, ring_rst, ring_x_init, ring_a,
           res_valid, res_data, res_last, busy, done
  );

  modport master (
    output start_valid, x_in, base_addr, mem_rdata, ring_y, res_ready,
    input  start_ready, mem_rd_en, mem_addr, ring_rst, ring_x_init, ring_a,
           res_valid, res_data, res_last, busy, done
  );
endinterface

// File: rtl/anillo_res_buf.sv
// Captures N_PE ring outputs in order and replays them on a valid/ready stream.
module anillo_res_buf import anillo_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         cap_en_i,
  input  logic [W-1:0] cap_data_i,
  output logic         cap_last_o,
  input  logic         out_en_i,
  input  logic         res_ready_i,
  output logic         res_valid_o,
  output logic [W-1:0] res_data_o,
  output logic         res_last_o,
  output logic         fire_last_o
);
  logic [W-1:0]     cap_q [N_PE];
  logic [IDX_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             fire;

  always_comb begin
    cap_last_o  = (wr_q == IDX_W'(N_PE-1));
    res_valid_o = out_en_i;
    res_data_o  = out_en_i ? cap_q[rd_q] : '0;
    res_last_o  = out_en_i && (rd_q == IDX_W'(N_PE-1));
    fire        = out_en_i && res_ready_i;
    fire_last_o = fire && res_last_o;
    wr_d        = wr_q;
    rd_d        = rd_q;
    if (cap_en_i) wr_d = cap_last_o ? '0 : wr_q + IDX_W'(1);
    if (fire)     rd_d = res_last_o ? '0 : rd_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < N_PE; i++) cap_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (cap_en_i) cap_q[wr_q] <= cap_data_i;
    end
  end
endmodule

// File: rtl/anillo_ctrl.sv
// Job sequencer for the 4-PE systolic ring: load x, stream matrix words, collect and return results.
module anillo_ctrl import anillo_pkg::*; #(
  parameter int N_STEPS   = 4,
  parameter int DRAIN_CYC = 1
) (
  input logic clk,
  input logic reset,
  anillo_if.slave bus
);
  localparam int CNT_W = 8;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lanes_t            x_q, x_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              start_ready_o, busy_o, ring_rst_o, mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  lanes_t            ring_a_o;
  logic              cap_last, fire_last;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    addr_d        = addr_q;
    start_ready_o = (state_q == IDLE);
    busy_o        = (state_q != IDLE);
    ring_rst_o    = reset || (state_q == LOAD);
    mem_rd_en_o   = 1'b0;
    mem_addr_o    = '0;
    ring_a_o      = '0;
    case (state_q)
      IDLE: if (bus.start_valid) begin
        x_d     = bus.x_in;
        addr_d  = bus.base_addr;
        state_d = LOAD;
      end
      LOAD: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = addr_q;
        cnt_d       = '0;
        state_d     = STEP;
      end
      STEP: begin
        ring_a_o = bus.mem_rdata;
        if (cnt_q == CNT_W'(N_STEPS-1)) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYC == 0) ? COLLECT : DRAIN;
        end else begin
          // Prefetch next word; address wraps modulo 2^ADDR_W.
          mem_rd_en_o = 1'b1;
          mem_addr_o  = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: if (cnt_q == CNT_W'(DRAIN_CYC-1)) begin
        cnt_d   = '0;
        state_d = COLLECT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      COLLECT: if (cap_last) state_d = OUT;
      OUT:     if (fire_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      addr_q  <= addr_d;
    end
  end

  anillo_res_buf u_res_buf (
    .clk         (clk),
    .reset       (reset),
    .cap_en_i    (state_q == COLLECT),
    .cap_data_i  (bus.ring_y),
    .cap_last_o  (cap_last),
    .out_en_i    (state_q == OUT),
    .res_ready_i (bus.res_ready),
    .res_valid_o (bus.res_valid),
    .res_data_o  (bus.res_data),
    .res_last_o  (bus.res_last),
    .fire_last_o (fire_last)
  );

  assign bus.start_ready = start_ready_o;
  assign bus.busy        = busy_o;
  assign bus.ring_rst    = ring_rst_o;
  assign bus.mem_rd_en   = mem_rd_en_o;
  assign bus.mem_addr    = mem_addr_o;
  assign bus.ring_a      = ring_a_o;
  assign bus.ring_x_init = x_q;
  assign bus.done        = fire_last;
endmodule
